pipe_stage_reg: RTL and testbench

- Parametrised elastic pipeline register for inter-stage boundaries of the 5-stage MIPS core: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Replaces the plain enable-only stage register. It adds a valid/ready handshake, a 2-entry skid buffer so that ready does not propagate combinationally through a stage, and a flush input for exception/eret.
- Carries the instruction/payload, PC, exception code and branch-delay flag.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_stage_reg.sv | 131 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared constants, stage-state encoding and entry type for the
//               elastic inter-stage pipeline registers.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_PC_W   = 32;
    localparam int PIPE_EXC_W  = 5;

    localparam logic [PIPE_EXC_W-1:0] EXC_NONE         = 5'd0;
    localparam logic [PIPE_PC_W-1:0]  RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    typedef struct packed {
        logic [PIPE_DATA_W-1:0] data;
        logic [PIPE_PC_W-1:0]   pc;
        logic [PIPE_EXC_W-1:0]  exc;
        logic                   bd;
    } stage_entry_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Elastic pipeline register (main + skid entry) with valid/ready
//               handshake and flush. Optional counters via PIPE_STAGE_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter int              PC_W     = 32,
    parameter int              EXC_W    = 5,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    input  logic [PC_W-1:0]   up_pc,
    input  logic [EXC_W-1:0]  up_exc,
    input  logic              up_bd,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [PC_W-1:0]   dn_pc,
    output logic [EXC_W-1:0]  dn_exc,
    output logic              dn_bd
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    // Entries share the package struct, so the field widths must line up.
    if (DATA_W != PIPE_DATA_W || PC_W != PIPE_PC_W || EXC_W != PIPE_EXC_W) begin : g_width_check
        $error("pipe_stage_reg: field widths must match pipe_pkg entry type");
    end

    stage_state_t r_state;
    stage_entry_t r_main;
    stage_entry_t r_skid;
    stage_entry_t w_up_entry;
    logic         w_acc;
    logic         w_pop;

    assign w_up_entry = '{data: up_data, pc: up_pc, exc: up_exc, bd: up_bd};

    assign up_ready = (r_state != ST_TWO);
    assign dn_valid = (r_state != ST_EMPTY);
    assign w_acc    = up_valid & up_ready;
    assign w_pop    = dn_valid & dn_ready;

    assign dn_data = r_main.data;
    assign dn_pc   = r_main.pc;
    assign dn_exc  = r_main.exc;
    assign dn_bd   = r_main.bd;

    // Whenever the main register goes empty its payload is zeroed so the
    // bubble decodes as a nop; the PC is kept for exception reporting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
            r_main  <= '{data: '0, pc: RESET_PC, exc: EXC_NONE, bd: 1'b0};
            r_skid  <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_main.data <= '0;
            r_main.exc  <= EXC_NONE;
            r_main.bd   <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_main  <= w_up_entry;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_pop) begin
                        r_main <= w_up_entry;
                    end else if (w_acc) begin
                        r_skid  <= w_up_entry;
                        r_state <= ST_TWO;
                    end else if (w_pop) begin
                        r_main.data <= '0;
                        r_main.exc  <= EXC_NONE;
                        r_main.bd   <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        r_main  <= r_skid;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (dn_valid && !dn_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush && dn_valid) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for pipe_stage_reg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        up_valid;
    logic        up_ready;
    logic [31:0] up_data;
    logic [31:0] up_pc;
    logic [4:0]  up_exc;
    logic        up_bd;
    logic        dn_valid;
    logic        dn_ready;
    logic [31:0] dn_data;
    logic [31:0] dn_pc;
    logic [4:0]  dn_exc;
    logic        dn_bd;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    pipe_stage_reg dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .up_valid (up_valid),
        .up_ready (up_ready),
        .up_data  (up_data),
        .up_pc    (up_pc),
        .up_exc   (up_exc),
        .up_bd    (up_bd),
        .dn_valid (dn_valid),
        .dn_ready (dn_ready),
        .dn_data  (dn_data),
        .dn_pc    (dn_pc),
        .dn_exc   (dn_exc),
        .dn_bd    (dn_bd)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] data);
        up_valid = 1'b1;
        up_pc    = pc;
        up_data  = data;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0;
        up_data = '0; up_pc = '0; up_exc = '0; up_bd = 1'b0;

        // Reset for two cycles
        tick(); tick();
        check("rst_valid", {31'd0, dn_valid}, 32'd0);
        check("rst_pc",    dn_pc,             32'h0000_3000);
        check("rst_data",  dn_data,           32'd0);
        check("rst_ready", {31'd0, up_ready}, 32'd1);
        reset = 1'b1;

        // Streaming at one entry per cycle
        dn_ready = 1'b1;
        push(32'h3000, 32'h1); tick();
        check("str0_valid", {31'd0, dn_valid}, 32'd1);
        check("str0_pc",    dn_pc,   32'h3000);
        push(32'h3004, 32'h2); tick();
        check("str1_pc",    dn_pc,   32'h3004);
        check("str1_data",  dn_data, 32'h2);
        push(32'h3008, 32'h3); tick();
        check("str2_pc",    dn_pc,   32'h3008);
        check("str2_valid", {31'd0, dn_valid}, 32'd1);
        up_valid = 1'b0; tick();
        check("str_end_valid", {31'd0, dn_valid}, 32'd0);
        check("str_end_data",  dn_data, 32'd0);

        // Backpressure fills the skid
        dn_ready = 1'b0;
        push(32'h3000, 32'h11); tick();
        check("bp0_pc",    dn_pc, 32'h3000);
        check("bp0_ready", {31'd0, up_ready}, 32'd1);
        push(32'h3004, 32'h12); tick();
        check("bp1_ready", {31'd0, up_ready}, 32'd0);
        check("bp1_pc",    dn_pc, 32'h3000);
        push(32'h3008, 32'h13); tick();
        check("bp2_pc",    dn_pc, 32'h3000);
        check("bp2_data",  dn_data, 32'h11);
        check("bp2_ready", {31'd0, up_ready}, 32'd0);
        up_valid = 1'b0; dn_ready = 1'b1; tick();
        check("bp3_pc",    dn_pc, 32'h3004);
        check("bp3_data",  dn_data, 32'h12);
        check("bp3_ready", {31'd0, up_ready}, 32'd1);
        tick();
        check("bp4_valid", {31'd0, dn_valid}, 32'd0);

        // Flush while two entries are held
        dn_ready = 1'b0;
        push(32'h3100, 32'h21); tick();
        push(32'h3104, 32'h22); tick();
        check("fl2_ready_pre", {31'd0, up_ready}, 32'd0);
        flush = 1'b1; push(32'h3108, 32'h23); tick();
        check("fl2_valid", {31'd0, dn_valid}, 32'd0);
        check("fl2_data",  dn_data, 32'd0);
        check("fl2_ready", {31'd0, up_ready}, 32'd1);
        check("fl2_pc",    dn_pc, 32'h3100);
        flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b1; tick();
        check("fl2_after", {31'd0, dn_valid}, 32'd0);

        // Flush in ONE with an accepted entry in the same cycle
        dn_ready = 1'b0;
        push(32'h3200, 32'h31); tick();
        flush = 1'b1; push(32'h3204, 32'h32); tick();
        check("fl1_valid", {31'd0, dn_valid}, 32'd0);
        flush = 1'b0; up_valid = 1'b0; tick();
        check("fl1_after", {31'd0, dn_valid}, 32'd0);
        check("fl1_data",  dn_data, 32'd0);

        // Bit-exact field transport, then reset during a hold
        push(32'h3300, 32'h8C01_0004); up_exc = 5'd10; up_bd = 1'b1; tick();
        check("fld_data", dn_data, 32'h8C01_0004);
        check("fld_pc",   dn_pc,   32'h3300);
        check("fld_exc",  {27'd0, dn_exc}, 32'd10);
        check("fld_bd",   {31'd0, dn_bd},  32'd1);
        up_valid = 1'b0; up_exc = 5'd0; up_bd = 1'b0; tick();
        check("fld_hold", dn_data, 32'h8C01_0004);
        reset = 1'b0; tick();
        check("rst2_valid", {31'd0, dn_valid}, 32'd0);
        check("rst2_pc",    dn_pc,   32'h3000);
        check("rst2_data",  dn_data, 32'd0);
        check("rst2_exc",   {27'd0, dn_exc}, 32'd0);
        check("rst2_bd",    {31'd0, dn_bd},  32'd0);
        check("rst2_ready", {31'd0, up_ready}, 32'd1);
        reset = 1'b1;

`ifdef PIPE_STAGE_PERF_EN
        check("perf_rst_stall", stall_cnt, 32'd0);
        push(32'h3400, 32'h41); tick();
        up_valid = 1'b0;
        tick(); tick(); tick(); tick();
        check("perf_stall4", stall_cnt, 32'd4);
        dn_ready = 1'b1; flush = 1'b1; tick();
        flush = 1'b0; dn_ready = 1'b0;
        check("perf_flush1", flush_cnt, 32'd1);
        check("perf_stall_kept", stall_cnt, 32'd4);
        dut.r_stall_cnt = 32'hFFFF_FFFF;
        push(32'h3500, 32'h51); tick();
        up_valid = 1'b0; tick();
        check("perf_wrap", stall_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire
